// File: rtl/ad_ip_jesd204_tpl_adc_pn_status_pkg.sv
// rtl/ad_ip_jesd204_tpl_adc_pn_status_pkg.sv - shared TPL ADC PN-status encodings
package ad_ip_jesd204_tpl_adc_pn_status_pkg;

  // pn_state encoding, decoded identically by the channel register map
  typedef logic [1:0] pn_state_t;

  localparam logic [1:0] PN_STATE_IDLE   = 2'd0;
  localparam logic [1:0] PN_STATE_SEARCH = 2'd1;
  localparam logic [1:0] PN_STATE_LOCKED = 2'd2;
  localparam logic [1:0] PN_STATE_LOST   = 2'd3;

  // PN sequence select codes, same encoding as the channel PN monitor
  localparam logic [3:0] PN_SEL_PN9  = 4'd0;
  localparam logic [3:0] PN_SEL_PN23 = 4'd1;
  localparam logic [3:0] PN_SEL_PN7  = 4'd4;
  localparam logic [3:0] PN_SEL_PN15 = 4'd5;

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_sat_cnt.sv
// rtl/ad_ip_jesd204_tpl_adc_sat_cnt.sv - saturating event counter, increment wins over clear
module ad_ip_jesd204_tpl_adc_sat_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // clear restarts the count; an event in the clear cycle leaves the count at 1
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? WIDTH'(1) : '0;
    end else if (inc && !(&count)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_pn_status.sv
// rtl/ad_ip_jesd204_tpl_adc_pn_status.sv - per-channel PN lock qualifier and error/loss statistics
module ad_ip_jesd204_tpl_adc_pn_status
  import ad_ip_jesd204_tpl_adc_pn_status_pkg::*;
#(
  parameter int ERR_CNT_WIDTH = 32,
  parameter int LOCK_CYCLES   = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic                     pn_oos,
  input  logic                     pn_err,
  input  logic [3:0]               pn_seq_sel,
  input  logic                     clr,
  output logic [1:0]               pn_state,
  output logic                     pn_locked,
  output logic                     pn_lost,
  output logic                     pn_err_sticky,
  output logic                     pn_oos_sticky,
  output logic [ERR_CNT_WIDTH-1:0] pn_err_count,
  output logic [ERR_CNT_WIDTH-1:0] pn_lost_count
);

  localparam int QW = $clog2(LOCK_CYCLES + 1);
  // qualifier value seen on the last clean cycle needed before lock
  localparam logic [QW-1:0] QUAL_LAST = QW'(LOCK_CYCLES - 1);

  pn_state_t     state;
  pn_state_t     state_next;
  logic [QW-1:0] qual;
  logic [QW-1:0] qual_next;
  logic [3:0]    seq_sel_q;
  logic          seq_change;
  logic          err_event;
  logic          lost_event;

  // a sequence switch invalidates any lock in progress or held
  assign seq_change = (pn_seq_sel != seq_sel_q) && (state != PN_STATE_IDLE);

  // next-state decode: disable beats sequence change beats normal tracking
  always_comb begin
    state_next = state;
    qual_next  = qual;
    err_event  = 1'b0;
    lost_event = 1'b0;
    if (!enable) begin
      state_next = PN_STATE_IDLE;
      qual_next  = '0;
    end else if (seq_change) begin
      state_next = PN_STATE_SEARCH;
      qual_next  = '0;
    end else begin
      case (state)
        PN_STATE_IDLE: begin
          state_next = PN_STATE_SEARCH;
          qual_next  = '0;
        end
        PN_STATE_SEARCH: begin
          if (pn_oos) begin
            qual_next = '0;
          end else if (qual == QUAL_LAST) begin
            state_next = PN_STATE_LOCKED;
            qual_next  = '0;
          end else begin
            qual_next = qual + QW'(1);
          end
        end
        PN_STATE_LOCKED: begin
          if (pn_oos) begin
            state_next = PN_STATE_LOST;
            lost_event = 1'b1;
          end else if (pn_err) begin
            err_event = 1'b1;
          end
        end
        PN_STATE_LOST: begin
          state_next = PN_STATE_SEARCH;
          qual_next  = '0;
        end
        default: begin
          state_next = PN_STATE_IDLE;
          qual_next  = '0;
        end
      endcase
    end
  end

  // state, qualifier and registered status flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= PN_STATE_IDLE;
      qual      <= '0;
      seq_sel_q <= PN_SEL_PN9;
      pn_locked <= 1'b0;
      pn_lost   <= 1'b0;
    end else begin
      state     <= state_next;
      qual      <= qual_next;
      seq_sel_q <= pn_seq_sel;
      pn_locked <= (state_next == PN_STATE_LOCKED);
      pn_lost   <= lost_event;
    end
  end

  // sticky flags: an event in the clear cycle keeps the flag set
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pn_err_sticky <= 1'b0;
      pn_oos_sticky <= 1'b0;
    end else begin
      pn_err_sticky <= err_event  | (pn_err_sticky & ~clr);
      pn_oos_sticky <= lost_event | (pn_oos_sticky & ~clr);
    end
  end

  assign pn_state = state;

  ad_ip_jesd204_tpl_adc_sat_cnt #(
    .WIDTH (ERR_CNT_WIDTH)
  ) i_err_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (err_event),
    .clr    (clr),
    .count  (pn_err_count)
  );

  ad_ip_jesd204_tpl_adc_sat_cnt #(
    .WIDTH (ERR_CNT_WIDTH)
  ) i_lost_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (lost_event),
    .clr    (clr),
    .count  (pn_lost_count)
  );

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pn_status.sv
// tb/tb_ad_ip_jesd204_tpl_adc_pn_status.sv - bench for the PN status tracker
module tb_ad_ip_jesd204_tpl_adc_pn_status;

  localparam int L  = 16;
  localparam int W  = 32;
  localparam int W2 = 2;

  localparam int M_IDLE   = 0;
  localparam int M_SEARCH = 1;
  localparam int M_LOCKED = 2;
  localparam int M_LOST   = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b0;
  logic pn_oos = 1'b0;
  logic pn_err = 1'b0;
  logic clr = 1'b0;
  logic [3:0] pn_seq_sel = 4'd0;

  logic [1:0]    st_a, st_b;
  logic          lk_a, lk_b, ls_a, ls_b, es_a, es_b, os_a, os_b;
  logic [W-1:0]  ec_a, lc_a;
  logic [W2-1:0] ec_b, lc_b;

  ad_ip_jesd204_tpl_adc_pn_status #(.ERR_CNT_WIDTH(W), .LOCK_CYCLES(L)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .pn_oos(pn_oos), .pn_err(pn_err),
    .pn_seq_sel(pn_seq_sel), .clr(clr), .pn_state(st_a), .pn_locked(lk_a), .pn_lost(ls_a),
    .pn_err_sticky(es_a), .pn_oos_sticky(os_a), .pn_err_count(ec_a), .pn_lost_count(lc_a)
  );

  ad_ip_jesd204_tpl_adc_pn_status #(.ERR_CNT_WIDTH(W2), .LOCK_CYCLES(L)) dut_w2 (
    .clk(clk), .resetn(resetn), .enable(enable), .pn_oos(pn_oos), .pn_err(pn_err),
    .pn_seq_sel(pn_seq_sel), .clr(clr), .pn_state(st_b), .pn_locked(lk_b), .pn_lost(ls_b),
    .pn_err_sticky(es_b), .pn_oos_sticky(os_b), .pn_err_count(ec_b), .pn_lost_count(lc_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: phase, clean-run length, event totals since last clear
  int         m_phase;
  int         m_run;
  longint     m_err;
  longint     m_lost;
  bit         m_err_st;
  bit         m_oos_st;
  logic [3:0] m_sel;
  logic [3:0] sel_cur = 4'd0;

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE; m_run = 0; m_err = 0; m_lost = 0;
    m_err_st = 0; m_oos_st = 0; m_sel = 4'd0;
  endtask

  task automatic model_update(input logic en, input logic oos, input logic err,
                              input logic [3:0] sel, input logic c);
    bit err_ev = 0;
    bit lost_ev = 0;
    if (!en) begin
      m_phase = M_IDLE; m_run = 0;
    end else if (m_phase != M_IDLE && sel != m_sel) begin
      m_phase = M_SEARCH; m_run = 0;
    end else if (m_phase == M_IDLE || m_phase == M_LOST) begin
      m_phase = M_SEARCH; m_run = 0;
    end else if (m_phase == M_LOCKED) begin
      if (oos) begin
        m_phase = M_LOST; lost_ev = 1;
      end else if (err) begin
        err_ev = 1;
      end
    end else begin
      m_run = oos ? 0 : m_run + 1;
      if (m_run == L) begin
        m_phase = M_LOCKED; m_run = 0;
      end
    end
    m_sel = sel;
    if (err_ev) m_err = c ? 1 : m_err + 1;
    else if (c) m_err = 0;
    if (lost_ev) m_lost = c ? 1 : m_lost + 1;
    else if (c) m_lost = 0;
    m_err_st = err_ev | (m_err_st & !c);
    m_oos_st = lost_ev | (m_oos_st & !c);
  endtask

  // drive one cycle of inputs, advance the model at the edge, return 1 ns after it
  task automatic tick(input logic en, input logic oos, input logic err,
                      input logic [3:0] sel, input logic c);
    enable = en; pn_oos = oos; pn_err = err; pn_seq_sel = sel; clr = c;
    @(posedge clk);
    model_update(en, oos, err, sel, c);
    #1;
  endtask

  task automatic go_locked();
    tick(0, 0, 0, sel_cur, 0);
    tick(1, 0, 0, sel_cur, 0);
    for (int i = 0; i < L; i++) tick(1, 0, 0, sel_cur, 0);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({st_a, lk_a, ls_a, es_a, os_a, ec_a, lc_a} !== '0) begin
      n_bad++; $display("FAIL reset_held: got %h want 0", {st_a, lk_a, ls_a, es_a, os_a, ec_a, lc_a});
    end
    @(posedge clk); @(negedge clk);
    resetn = 1'b1;
    model_reset();
    tick(0, 0, 0, 4'd0, 0);
    n_cmp++;
    if ({st_b, lk_b, ls_b, es_b, os_b, ec_b, lc_b} !== '0) begin
      n_bad++; $display("FAIL reset_release: got %h want 0", {st_b, lk_b, ls_b, es_b, os_b, ec_b, lc_b});
    end
  endtask

  task automatic test_lock_latency();
    int k = 0;
    tick(1, 0, 0, sel_cur, 0);
    n_cmp++;
    if (st_a !== 2'd1) begin
      n_bad++; $display("FAIL enter_search: got %0d want 1", st_a);
    end
    while (!lk_a && k < 100) begin
      tick(1, 0, 0, sel_cur, 0);
      k++;
    end
    n_cmp++;
    if (k !== L) begin
      n_bad++; $display("FAIL lock_latency: got %0d want %0d", k, L);
    end
    n_cmp++;
    if (ec_a !== 0 || lc_a !== 0 || st_a !== 2'd2) begin
      n_bad++; $display("FAIL lock_counts: got st=%0d ec=%0d lc=%0d want 2/0/0", st_a, ec_a, lc_a);
    end
  endtask

  task automatic test_requalify();
    int k = 0;
    tick(0, 0, 0, sel_cur, 0);
    tick(1, 0, 0, sel_cur, 0);
    for (int i = 0; i < L - 1; i++) tick(1, 0, 0, sel_cur, 0);
    n_cmp++;
    if (lk_a !== 1'b0) begin
      n_bad++; $display("FAIL early_lock: got %0d want 0", lk_a);
    end
    tick(1, 1, 0, sel_cur, 0);
    while (!lk_a && k < 100) begin
      tick(1, 0, 0, sel_cur, 0);
      k++;
    end
    n_cmp++;
    if (k !== L || ls_a !== 1'b0) begin
      n_bad++; $display("FAIL requalify: got %0d cycles lost=%0d want %0d/0", k, ls_a, L);
    end
  endtask

  task automatic test_err_loss();
    go_locked();
    tick(1, 0, 0, sel_cur, 1);
    for (int i = 0; i < 5; i++) tick(1, 0, 1, sel_cur, 0);
    tick(1, 1, 1, sel_cur, 0);
    n_cmp++;
    if ({ls_a, st_a, es_a, os_a} !== 5'b1_11_11 || ec_a !== 5 || lc_a !== 1) begin
      n_bad++; $display("FAIL err_loss: got lost=%0d st=%0d es=%0d os=%0d ec=%0d lc=%0d want 1/3/1/1/5/1",
                        ls_a, st_a, es_a, os_a, ec_a, lc_a);
    end
    tick(1, 0, 0, sel_cur, 0);
    n_cmp++;
    if (ls_a !== 1'b0 || st_a !== 2'd1 || lc_a !== 1) begin
      n_bad++; $display("FAIL after_loss: got lost=%0d st=%0d lc=%0d want 0/1/1", ls_a, st_a, lc_a);
    end
  endtask

  task automatic test_saturation();
    go_locked();
    tick(1, 0, 0, sel_cur, 1);
    for (int i = 0; i < 6; i++) tick(1, 0, 1, sel_cur, 0);
    n_cmp++;
    if (ec_b !== 2'd3 || ec_a !== 6 || es_b !== 1'b1) begin
      n_bad++; $display("FAIL saturate: got w2=%0d w32=%0d sticky=%0d want 3/6/1", ec_b, ec_a, es_b);
    end
    tick(1, 0, 1, sel_cur, 1);
    n_cmp++;
    if (ec_b !== 2'd1 || ec_a !== 1 || es_a !== 1'b1 || es_b !== 1'b1) begin
      n_bad++; $display("FAIL clr_vs_event: got w2=%0d w32=%0d es=%0d%0d want 1/1/11", ec_b, ec_a, es_a, es_b);
    end
    tick(1, 0, 0, sel_cur, 1);
    n_cmp++;
    if (ec_a !== 0 || es_a !== 1'b0 || os_a !== 1'b0 || st_a !== 2'd2) begin
      n_bad++; $display("FAIL clr_only: got ec=%0d es=%0d os=%0d st=%0d want 0/0/0/2", ec_a, es_a, os_a, st_a);
    end
  endtask

  task automatic test_seq_change();
    sel_cur = 4'd0;
    go_locked();
    tick(1, 0, 0, sel_cur, 1);
    tick(1, 0, 1, sel_cur, 0);
    tick(1, 0, 1, sel_cur, 0);
    sel_cur = 4'd1;
    tick(1, 0, 1, sel_cur, 0);
    n_cmp++;
    if (st_a !== 2'd1 || ls_a !== 1'b0 || ec_a !== 2 || lc_a !== 0 || lk_a !== 1'b0) begin
      n_bad++; $display("FAIL seq_change: got st=%0d lost=%0d ec=%0d lc=%0d lk=%0d want 1/0/2/0/0",
                        st_a, ls_a, ec_a, lc_a, lk_a);
    end
  endtask

  task automatic test_enable_drop();
    go_locked();
    tick(1, 0, 0, sel_cur, 1);
    for (int i = 0; i < 7; i++) tick(1, 0, 1, sel_cur, 0);
    tick(0, 1, 1, sel_cur, 0);
    n_cmp++;
    if (st_a !== 2'd0 || lk_a !== 1'b0 || ec_a !== 7 || ec_b !== 2'd3 || lc_a !== 0) begin
      n_bad++; $display("FAIL enable_drop: got st=%0d lk=%0d ec=%0d w2=%0d lc=%0d want 0/0/7/3/0",
                        st_a, lk_a, ec_a, ec_b, lc_a);
    end
  endtask

  task automatic test_async_reset();
    tick(1, 0, 0, sel_cur, 0);
    tick(1, 0, 0, sel_cur, 0);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({st_a, lk_a, ls_a, es_a, os_a, ec_a, lc_a, st_b, ec_b} !== '0) begin
      n_bad++; $display("FAIL async_reset: got %h want 0", {st_a, lk_a, ls_a, es_a, os_a, ec_a, lc_a});
    end
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    logic [69:0] exp_a;
    logic [9:0]  exp_b;
    logic [3:0]  codes [4] = '{4'd0, 4'd1, 4'd4, 4'd5};
    logic en, oos, err, c;
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 199) != 0);
      oos = ($urandom_range(0, 39) == 0);
      err = ($urandom_range(0, 3) == 0);
      c   = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 149) == 0) sel_cur = codes[$urandom_range(0, 3)];
      tick(en, oos, err, sel_cur, c);
      exp_a = {2'(m_phase), m_phase == M_LOCKED, m_phase == M_LOST, m_err_st, m_oos_st,
               32'(sat(m_err, W)), 32'(sat(m_lost, W))};
      exp_b = {2'(m_phase), m_phase == M_LOCKED, m_phase == M_LOST, m_err_st, m_oos_st,
               2'(sat(m_err, W2)), 2'(sat(m_lost, W2))};
      n_cmp++;
      if ({st_a, lk_a, ls_a, es_a, os_a, ec_a, lc_a} !== exp_a) begin
        n_bad++; $display("FAIL random_w32 cyc %0d: got %h want %h", i,
                          {st_a, lk_a, ls_a, es_a, os_a, ec_a, lc_a}, exp_a);
      end
      n_cmp++;
      if ({st_b, lk_b, ls_b, es_b, os_b, ec_b, lc_b} !== exp_b) begin
        n_bad++; $display("FAIL random_w2 cyc %0d: got %h want %h", i,
                          {st_b, lk_b, ls_b, es_b, os_b, ec_b, lc_b}, exp_b);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_latency();
    test_requalify();
    test_err_loss();
    test_saturation();
    test_seq_change();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
